// File: rtl/biker_shot_pkg.sv
// -----------------------------------------------------------------------------
// biker_shot_pkg
// Shared types and constants for the biker shot pool.
//   shot_state_t            : life cycle of one projectile slot
//   shot_slot_t             : registered contents of one slot
//   FIXED_POINT_MULTIPLIER  : sub-pixel scale of every stored position/speed
// -----------------------------------------------------------------------------
package biker_shot_pkg;

   localparam int FIXED_POINT_MULTIPLIER = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLYING  = 2'd1,
      EXPLODE = 2'd2
   } shot_state_t;

   typedef struct packed {
      shot_state_t        state;
      logic signed [31:0] x;           // top-left X, 1/FPM pixel
      logic signed [31:0] y;           // top-left Y, 1/FPM pixel
      logic signed [31:0] vx;          // lateral speed, latched at spawn
      logic [7:0]         explodeCnt;  // frames left in EXPLODE
   } shot_slot_t;

endpackage

// File: rtl/biker_shot_slot.sv
// -----------------------------------------------------------------------------
// biker_shot_slot
// One projectile slot: IDLE -> FLYING -> (IDLE | EXPLODE -> IDLE), per-frame
// motion integration, frame-edge retirement and the pixel coverage test.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   startOfFrame            per-frame update strobe
//   spawn                   load spawnX/spawnY/spawnVx and start FLYING
//   hit                     collision on this slot (only honoured while FLYING)
//   pixelX, pixelY          current VGA pixel
//   active                  slot is FLYING or EXPLODE
//   exploding               slot is EXPLODE
//   covers                  active and the pixel lies inside the shot box
// -----------------------------------------------------------------------------
module biker_shot_slot
   import biker_shot_pkg::*;
#(
   parameter int SHOT_SPEED_Y    = 256,
   parameter int SHOT_W          = 8,
   parameter int SHOT_H          = 8,
   parameter int FRAME_MAX_WIDTH = 639,
   parameter int EXPLODE_FRAMES  = 4
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               spawn,
   input  logic signed [31:0] spawnX,
   input  logic signed [31:0] spawnY,
   input  logic signed [31:0] spawnVx,
   input  logic               hit,
   input  logic [10:0]        pixelX,
   input  logic [10:0]        pixelY,
   output logic               active,
   output logic               exploding,
   output logic               covers
);

   localparam int MAX_X = (FRAME_MAX_WIDTH - SHOT_W) * FIXED_POINT_MULTIPLIER;

   shot_slot_t         slot_r;
   shot_slot_t         slot_s;
   logic signed [31:0] posX_s;
   logic signed [31:0] posY_s;
   logic signed [31:0] movedX_s;
   logic signed [31:0] movedY_s;
   logic signed [31:0] pixX_s;
   logic signed [31:0] pixY_s;
   logic signed [31:0] sx_s;
   logic signed [31:0] sy_s;

   assign posX_s   = slot_r.x;
   assign posY_s   = slot_r.y;
   assign movedX_s = posX_s + slot_r.vx;
   assign movedY_s = posY_s - SHOT_SPEED_Y;

   // Slot state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_r <= '0;
      end else begin
         slot_r <= slot_s;
      end
   end

   // Next-state: spawn, then hit (freezes position), then frame integration.
   always_comb begin
      slot_s = slot_r;
      if (spawn) begin
         slot_s.state      = FLYING;
         slot_s.x          = spawnX;
         slot_s.y          = spawnY;
         slot_s.vx         = spawnVx;
         slot_s.explodeCnt = 8'd0;
      end else if (hit && (slot_r.state == FLYING)) begin
         slot_s.state      = EXPLODE;
         slot_s.explodeCnt = 8'(EXPLODE_FRAMES);
      end else if (startOfFrame) begin
         case (slot_r.state)
            FLYING: begin
               if ((movedY_s < 32'sd0) || (movedX_s < 32'sd0) || (movedX_s > MAX_X)) begin
                  slot_s.state = IDLE;
               end else begin
                  slot_s.x = movedX_s;
                  slot_s.y = movedY_s;
               end
            end
            EXPLODE: begin
               // Counter reaching zero retires the slot on this same frame.
               if (slot_r.explodeCnt <= 8'd1) begin
                  slot_s.state      = IDLE;
                  slot_s.explodeCnt = 8'd0;
               end else begin
                  slot_s.explodeCnt = slot_r.explodeCnt - 8'd1;
               end
            end
            default: begin
               slot_s = slot_r;
            end
         endcase
      end else begin
         slot_s = slot_r;
      end
   end

   // Pixel coordinates truncate toward zero, which signed division gives.
   assign sx_s   = posX_s / FIXED_POINT_MULTIPLIER;
   assign sy_s   = posY_s / FIXED_POINT_MULTIPLIER;
   assign pixX_s = {21'd0, pixelX};
   assign pixY_s = {21'd0, pixelY};

   assign active    = (slot_r.state == FLYING) || (slot_r.state == EXPLODE);
   assign exploding = (slot_r.state == EXPLODE);
   assign covers    = active &&
                      (pixX_s >= sx_s) && (pixX_s < (sx_s + SHOT_W)) &&
                      (pixY_s >= sy_s) && (pixY_s < (sy_s + SHOT_H));

endmodule

// File: rtl/biker_shot_pool.sv
// -----------------------------------------------------------------------------
// biker_shot_pool
// Pool of NUM_SHOTS projectiles fired from the biker. Holds the lowest-free-slot
// allocator, the fire cooldown and the registered draw priority mux.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   startOfFrame                 per-frame strobe (motion, cooldown, explosions)
//   shootRequest                 fire pulse from the biker mover
//   bikerTopLeftX/Y              biker top-left, signed pixels
//   movingRight/movingLeft       biker motion, sets the shot's lateral drift
//   hitShot, hitIndex            collision report for one slot
//   pixelX, pixelY               current VGA pixel
//   shotDrawingRequest           registered: pixel inside an active shot
//   shotIndex                    registered: lowest covering slot
//   shotExploding                registered: that slot is exploding
//   shotFired / shotDropped      registered one-cycle accept / reject pulses
//   activeMask                   per-slot FLYING-or-EXPLODE, decoded from state
// -----------------------------------------------------------------------------
module biker_shot_pool
   import biker_shot_pkg::*;
#(
   parameter int NUM_SHOTS       = 4,
   parameter int SHOT_SPEED_Y    = 256,
   parameter int SHOT_DRIFT_X    = 64,
   parameter int BIKER_W         = 32,
   parameter int SHOT_W          = 8,
   parameter int SHOT_H          = 8,
   parameter int FRAME_MAX_WIDTH = 639,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int EXPLODE_FRAMES  = 4
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 startOfFrame,
   input  logic                 shootRequest,
   input  logic signed [10:0]   bikerTopLeftX,
   input  logic signed [10:0]   bikerTopLeftY,
   input  logic                 movingRight,
   input  logic                 movingLeft,
   input  logic                 hitShot,
   input  logic [2:0]           hitIndex,
   input  logic [10:0]          pixelX,
   input  logic [10:0]          pixelY,
   output logic                 shotDrawingRequest,
   output logic [2:0]           shotIndex,
   output logic                 shotExploding,
   output logic                 shotFired,
   output logic                 shotDropped,
   output logic [NUM_SHOTS-1:0] activeMask
);

   logic [NUM_SHOTS-1:0] freeVec_s;
   logic [NUM_SHOTS-1:0] coverMask_s;
   logic [NUM_SHOTS-1:0] explodeMask_s;
   logic                 found_s;
   logic                 accept_s;
   logic [7:0]           cooldown_r;
   logic signed [31:0]   spawnX_s;
   logic signed [31:0]   spawnY_s;
   logic signed [31:0]   spawnVx_s;
   logic                 drawHit_s;
   logic [2:0]           drawIdx_s;
   logic                 drawExp_s;

   // Spawn position centred on the biker, just above its top edge.
   always_comb begin
      spawnX_s = (32'(bikerTopLeftX) + 32'(BIKER_W / 2) - 32'(SHOT_W / 2)) * FIXED_POINT_MULTIPLIER;
      spawnY_s = (32'(bikerTopLeftY) - 32'(SHOT_H)) * FIXED_POINT_MULTIPLIER;
      if (movingRight) begin
         spawnVx_s = 32'(SHOT_DRIFT_X);
      end else if (movingLeft) begin
         spawnVx_s = -32'(SHOT_DRIFT_X);
      end else begin
         spawnVx_s = 32'sd0;
      end
   end

   // Allocator: one-hot of the lowest slot that is IDLE in registered state.
   always_comb begin
      freeVec_s = '0;
      found_s   = 1'b0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
         if (!activeMask[i] && !found_s) begin
            freeVec_s[i] = 1'b1;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      accept_s = shootRequest && (cooldown_r == 8'd0) && found_s;
   end

   for (genvar g = 0; g < NUM_SHOTS; g++) begin : gSlot
      biker_shot_slot #(
         .SHOT_SPEED_Y   (SHOT_SPEED_Y),
         .SHOT_W         (SHOT_W),
         .SHOT_H         (SHOT_H),
         .FRAME_MAX_WIDTH(FRAME_MAX_WIDTH),
         .EXPLODE_FRAMES (EXPLODE_FRAMES)
      ) uSlot (
         .clk         (clk),
         .reset       (reset),
         .startOfFrame(startOfFrame),
         .spawn       (accept_s && freeVec_s[g]),
         .spawnX      (spawnX_s),
         .spawnY      (spawnY_s),
         .spawnVx     (spawnVx_s),
         .hit         (hitShot && (hitIndex == 3'(g))),
         .pixelX      (pixelX),
         .pixelY      (pixelY),
         .active      (activeMask[g]),
         .exploding   (explodeMask_s[g]),
         .covers      (coverMask_s[g])
      );
   end

   // Cooldown: reload on accept beats the per-frame decrement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cooldown_r <= 8'd0;
      end else if (accept_s) begin
         cooldown_r <= 8'(COOLDOWN_FRAMES);
      end else if (startOfFrame && (cooldown_r != 8'd0)) begin
         cooldown_r <= cooldown_r - 8'd1;
      end else begin
         cooldown_r <= cooldown_r;
      end
   end

   // Draw priority: scanning downward leaves the lowest covering slot.
   always_comb begin
      drawHit_s = 1'b0;
      drawIdx_s = 3'd0;
      drawExp_s = 1'b0;
      for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
         if (coverMask_s[i]) begin
            drawHit_s = 1'b1;
            drawIdx_s = 3'(i);
            drawExp_s = explodeMask_s[i];
         end else begin
            drawHit_s = drawHit_s;
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shotDrawingRequest <= 1'b0;
         shotIndex          <= 3'd0;
         shotExploding      <= 1'b0;
         shotFired          <= 1'b0;
         shotDropped        <= 1'b0;
      end else begin
         shotDrawingRequest <= drawHit_s;
         shotIndex          <= drawIdx_s;
         shotExploding      <= drawExp_s;
         shotFired          <= accept_s;
         shotDropped        <= shootRequest && !accept_s;
      end
   end

endmodule
